flyback_pwm_core: RTL
=====================

# flyback_pwm_core

Single-channel PWM generator for the flyback primary switch. It sits directly downstream of the system_controller AXI4-Lite register bank and turns its period, duty, duty-limit and soft-start registers into a gate-drive waveform. The block double-buffers configuration so that updates take effect only on switching-period boundaries. It also provides a soft-start ramp and a latched fault shutdown.

## Interface
- CNT_W, 16, width of period counter and duty values
- STEP_W, 8, width of soft-start increment
- ACLK  in  1  clock; all logic on rising edge
- ARESETN  in  1  asynchronous active-low reset
- cfg_enable  in  1  level; 1 = run converter
- cfg_period  in  CNT_W  switching period in ACLK cycles
- cfg_duty  in  CNT_W  target on-time in ACLK cycles
- cfg_duty_max  in  CNT_W  on-time ceiling
- cfg_ss_step  in  STEP_W  soft-start increment per period; 0 = no ramp
- cfg_update  in  1  one-cycle pulse: capture cfg_period/duty/duty_max/ss_step into pending set
- fault_in  in  1  synchronous over-current level, active high
- fault_clr  in  1  one-cycle pulse: clear latched fault
- pwm_out  out  1  registered gate drive
- cycle_start  out  1  one-cycle pulse when counter is 0 in an active state
- duty_active  out  CNT_W  on-time currently applied
- state  out  2  0 IDLE, 1 SOFTSTART, 2 RUN, 3 FAULT
- fault_latched  out  1  1 while in FAULT

## Operation
- Registers: pending set (P), active set (A), counter cnt, duty_cur.
- cfg_update loads P on the same edge. Outside IDLE, P is copied to A on the edge where cnt wraps to 0. In IDLE, P is copied to A continuously.
- Effective period per = max(A.period, 2). Effective target tgt = min(A.duty, A.duty_max, per-1).
- cnt counts 0..per-1 and wraps to 0. It is held at 0 in IDLE and FAULT.
- pwm_out for the cycle in which cnt=k is (k < duty_cur), in SOFTSTART/RUN only. Otherwise pwm_out is 0.
- IDLE -> SOFTSTART when cfg_enable=1 and fault_in=0. On entry, duty_cur=0 and cnt=0. If ss_step=0, the transition goes directly to RUN and duty_cur=tgt.
- SOFTSTART: at each wrap, duty_cur = min(duty_cur + ss_step, tgt) with saturating add. When the result equals tgt, the state moves to RUN on that same edge.
- RUN: at each wrap, duty_cur = tgt, so new duty takes effect immediately at the boundary. If tgt later rises above duty_cur, the state stays in RUN; there is no re-ramp.
- Any active state -> IDLE when cfg_enable=0. pwm_out goes low on the next edge, mid-period if necessary. cnt and duty_cur go to 0.
- Any state -> FAULT when fault_in=1. Fault has priority over enable and update. pwm_out=0 from the next edge, duty_cur=0, fault_latched=1.
- FAULT -> IDLE on fault_clr=1 with fault_in=0. If fault_in=1 at the time, fault_clr is ignored. From IDLE, the block re-enters SOFTSTART if cfg_enable is still 1.
- cfg_update coincident with a wrap: the new values go to P and are applied at the following wrap. A is loaded from the old P.

## Timing
- Reset: pwm_out=0, cycle_start=0, duty_active=0, state=IDLE, fault_latched=0. cnt, duty_cur, P and A are all 0.
- Enable-to-first-edge latency: cfg_enable sampled high at edge N gives state=SOFTSTART, cnt=0 and cycle_start=1 in cycle N+1. pwm_out=1 from cycle N+1 if duty_cur>0.
- fault_in is sampled at edge N. pwm_out=0 and state=FAULT hold from N+1. The response is never later than one edge.
- duty_active equals duty_cur, registered.
- A change to per or tgt is visible only from the cycle in which cnt=0 after the wrap.
- duty_cur ≥ per cannot occur, because it is clamped via tgt. pwm_out therefore always has at least one low cycle per period.

## Test plan
- Reset mid-run: assert ARESETN low while pwm_out=1 -> all outputs 0 immediately, asynchronously; state=IDLE.
- period=10, duty=4, duty_max=8, ss_step=0, enable -> RUN directly. pwm_out is 4 high / 6 low, repeating. cycle_start fires every 10 cycles.
- period=10, duty=6, duty_max=8, ss_step=2 -> duty_active goes 2, 4, 6 on successive wraps, with state=RUN at 6. Then set duty=9 with update -> applied as 8 (duty_max) at the next wrap.
- period=4, duty=10, duty_max=10 -> tgt=3, and pwm_out is 3 high / 1 low. period=1 -> per=2, and pwm_out is 1 high / 1 low.
- Update mid-period: with period=10, pulse cfg_update with period=20 at cnt=5 -> the current period still ends at cnt=9, and the next period is 20 cycles.
- Fault during RUN: fault_in=1 at cnt=2 -> pwm_out=0 at the next edge and state=FAULT. A fault_clr pulse while fault_in=1 -> the block stays in FAULT. A fault_clr pulse after fault_in=0 -> IDLE, then SOFTSTART the following cycle with duty_cur=0.

Source files
------------

// File: rtl/flyback_pwm_core_if.sv
// Configuration, fault and gate-drive signals between the register bank and the PWM core.
interface flyback_pwm_core_if #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned STEP_W = 8
);
  logic              cfg_enable;
  logic [CNT_W-1:0]  cfg_period;
  logic [CNT_W-1:0]  cfg_duty;
  logic [CNT_W-1:0]  cfg_duty_max;
  logic [STEP_W-1:0] cfg_ss_step;
  logic              cfg_update;
  logic              fault_in;
  logic              fault_clr;
  logic              pwm_out;
  logic              cycle_start;
  logic [CNT_W-1:0]  duty_active;
  logic [1:0]        state;
  logic              fault_latched;

  // Register bank / supervisor side.
  modport master (
    output cfg_enable, cfg_period, cfg_duty, cfg_duty_max, cfg_ss_step, cfg_update,
    output fault_in, fault_clr,
    input  pwm_out, cycle_start, duty_active, state, fault_latched
  );

  // PWM core side.
  modport slave (
    input  cfg_enable, cfg_period, cfg_duty, cfg_duty_max, cfg_ss_step, cfg_update,
    input  fault_in, fault_clr,
    output pwm_out, cycle_start, duty_active, state, fault_latched
  );
endinterface

// File: rtl/flyback_pwm_core.sv
// Single-channel flyback PWM: double-buffered config, soft-start ramp, latched fault shutdown.
module flyback_pwm_core #(
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned STEP_W = 8
) (
  input  logic               ACLK,
  input  logic               ARESETN,
  flyback_pwm_core_if.slave  bus_io
);

  typedef struct packed {
    logic [CNT_W-1:0]  period;
    logic [CNT_W-1:0]  duty;
    logic [CNT_W-1:0]  duty_max;
    logic [STEP_W-1:0] ss_step;
  } cfg_t;

  typedef enum logic [1:0] {
    StIdle      = 2'd0,
    StSoftStart = 2'd1,
    StRun       = 2'd2,
    StFault     = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] duty_cur_q, duty_cur_d;
  logic             pwm_q, pwm_d;
  cfg_t             p_q, p_d;
  cfg_t             a_q, a_d;

  // Active set as it will be after this edge; decisions taken on this edge use it so that
  // a new period and its duty start together.
  cfg_t             a_nxt;
  logic [CNT_W-1:0] per_cur;
  logic [CNT_W-1:0] per_nxt;
  logic [CNT_W-1:0] tgt_nxt;
  logic [CNT_W:0]   ss_sum;
  logic             active_q;
  logic             wrap;

  // Effective period/target and period-boundary detection.
  always_comb begin
    active_q = (state_q == StSoftStart) || (state_q == StRun);
    per_cur  = (a_q.period < CNT_W'(2)) ? CNT_W'(2) : a_q.period;
    wrap     = active_q && (cnt_q >= (per_cur - CNT_W'(1)));
    a_nxt    = ((state_q == StIdle) || wrap) ? p_q : a_q;
    per_nxt  = (a_nxt.period < CNT_W'(2)) ? CNT_W'(2) : a_nxt.period;
    tgt_nxt  = a_nxt.duty;
    if (a_nxt.duty_max < tgt_nxt) begin
      tgt_nxt = a_nxt.duty_max;
    end
    // Clamping to per-1 guarantees at least one low cycle each period.
    if ((per_nxt - CNT_W'(1)) < tgt_nxt) begin
      tgt_nxt = per_nxt - CNT_W'(1);
    end
    // One extra bit makes the ramp add saturate naturally against tgt.
    ss_sum = {1'b0, duty_cur_q} + (CNT_W + 1)'(a_nxt.ss_step);
  end

  // Next-state, counter, duty and config-buffer logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    duty_cur_d = duty_cur_q;
    a_d        = a_nxt;
    p_d        = p_q;

    if (bus_io.cfg_update) begin
      p_d.period   = bus_io.cfg_period;
      p_d.duty     = bus_io.cfg_duty;
      p_d.duty_max = bus_io.cfg_duty_max;
      p_d.ss_step  = bus_io.cfg_ss_step;
    end

    if (bus_io.fault_in) begin
      // Fault overrides enable and update from any state.
      state_d    = StFault;
      cnt_d      = '0;
      duty_cur_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d      = '0;
          duty_cur_d = '0;
          if (bus_io.cfg_enable) begin
            if (a_nxt.ss_step == '0) begin
              state_d    = StRun;
              duty_cur_d = tgt_nxt;
            end else begin
              state_d    = StSoftStart;
            end
          end
        end
        StSoftStart: begin
          if (!bus_io.cfg_enable) begin
            state_d    = StIdle;
            cnt_d      = '0;
            duty_cur_d = '0;
          end else if (wrap) begin
            cnt_d = '0;
            if (ss_sum >= {1'b0, tgt_nxt}) begin
              duty_cur_d = tgt_nxt;
              state_d    = StRun;
            end else begin
              duty_cur_d = ss_sum[CNT_W-1:0];
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StRun: begin
          if (!bus_io.cfg_enable) begin
            state_d    = StIdle;
            cnt_d      = '0;
            duty_cur_d = '0;
          end else if (wrap) begin
            // No re-ramp: a raised target is applied in one step.
            cnt_d      = '0;
            duty_cur_d = tgt_nxt;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        StFault: begin
          cnt_d      = '0;
          duty_cur_d = '0;
          if (bus_io.fault_clr) begin
            state_d = StIdle;
          end
        end
        default: begin
          state_d    = StIdle;
          cnt_d      = '0;
          duty_cur_d = '0;
        end
      endcase
    end

    // Gate level for the cycle the new counter value describes.
    pwm_d = ((state_d == StSoftStart) || (state_d == StRun)) && (cnt_d < duty_cur_d);
  end

  // State, counter, duty and config registers.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      duty_cur_q <= '0;
      pwm_q      <= 1'b0;
      p_q        <= '0;
      a_q        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      duty_cur_q <= duty_cur_d;
      pwm_q      <= pwm_d;
      p_q        <= p_d;
      a_q        <= a_d;
    end
  end

  // Outputs; cycle_start decodes registered state so it stays zero during reset.
  always_comb begin
    bus_io.pwm_out       = pwm_q;
    bus_io.cycle_start   = active_q && (cnt_q == '0);
    bus_io.duty_active   = duty_cur_q;
    bus_io.state         = state_q;
    bus_io.fault_latched = (state_q == StFault);
  end

endmodule
